cond_exec_stage: RTL and testbench

//  Sits directly downstream of the 32-bit ALU (result + {N,Z,C,V}).
//  - Holds the architectural NZCV flag register.
//  - Evaluates the 4-bit condition field against the stored flags.
//  - Gates PC/register/memory writes on that condition.
//  - Registers the result into the writeback stage with a valid/stall/flush handshake.

---
 rtl/cond_exec_stage_pkg.sv | 32 +++
 rtl/cond_exec_stage_cond_check.sv | 40 ++++
 rtl/cond_exec_stage.sv | 84 ++++++++
 tb/tb_cond_exec_stage.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/cond_exec_stage_pkg.sv
// Shared constants for the condition/writeback stage: condition codes, NZCV bit
// positions and the packed writeback control bundle.
package cond_exec_stage_pkg;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef struct packed {
    logic pc_src;
    logic reg_write;
    logic mem_write;
  } wb_ctrl_t;

endpackage

// File: rtl/cond_exec_stage_cond_check.sv
// Pure combinational decode of a 4-bit condition field against stored NZCV flags.
// Zero latency, no handshake; the reserved code 1111 never passes.
module cond_exec_stage_cond_check
  import cond_exec_stage_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       cond_ex
);

  logic n, z, c, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      COND_EQ: cond_ex = z;
      COND_NE: cond_ex = ~z;
      COND_CS: cond_ex = c;
      COND_CC: cond_ex = ~c;
      COND_MI: cond_ex = n;
      COND_PL: cond_ex = ~n;
      COND_VS: cond_ex = v;
      COND_VC: cond_ex = ~v;
      COND_HI: cond_ex = c & ~z;
      COND_LS: cond_ex = ~c | z;
      COND_GE: cond_ex = (n == v);
      COND_LT: cond_ex = (n != v);
      COND_GT: cond_ex = ~z & (n == v);
      COND_LE: cond_ex = z | (n != v);
      COND_AL: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_exec_stage.sv
// Holds NZCV, gates PC/reg/mem writes on the condition, registers into writeback.
// 1-cycle latency; stall freezes flags and writeback, flush (higher priority) clears valid/strobes.
module cond_exec_stage
  import cond_exec_stage_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ex_valid,
  input  logic          stall,
  input  logic          flush,
  input  logic [3:0]    cond,
  input  logic [3:0]    alu_flags,
  input  logic [1:0]    flag_w,
  input  logic          pcs,
  input  logic          reg_w,
  input  logic          mem_w,
  input  logic          no_write,
  input  logic [DW-1:0] alu_result,
  input  logic [AW-1:0] wa3,
  output logic          cond_ex,
  output logic [3:0]    flags,
  output logic          wb_valid,
  output logic          pc_src,
  output logic          reg_write,
  output logic          mem_write,
  output logic [DW-1:0] wb_result,
  output logic [AW-1:0] wb_wa3
);

  logic     fire;
  wb_ctrl_t ctrl_nxt;
  wb_ctrl_t ctrl_q;

  // Condition is judged against the flags before this instruction's own update.
  cond_exec_stage_cond_check u_cond_check (
    .cond    (cond),
    .flags   (flags),
    .cond_ex (cond_ex)
  );

  assign fire = ex_valid & cond_ex & ~stall & ~flush;

  always_comb begin
    ctrl_nxt           = '0;
    ctrl_nxt.pc_src    = ex_valid & cond_ex & pcs;
    ctrl_nxt.reg_write = ex_valid & cond_ex & reg_w & ~no_write;
    ctrl_nxt.mem_write = ex_valid & cond_ex & mem_w;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags <= '0;
    end else if (fire) begin
      if (flag_w[1]) flags[FLAG_N:FLAG_Z] <= alu_flags[FLAG_N:FLAG_Z];
      if (flag_w[0]) flags[FLAG_C:FLAG_V] <= alu_flags[FLAG_C:FLAG_V];
    end
  end

  // Flush kills only valid/strobes; data fields are left as-is since nothing consumes them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid  <= 1'b0;
      ctrl_q    <= '0;
      wb_result <= '0;
      wb_wa3    <= '0;
    end else if (flush) begin
      wb_valid  <= 1'b0;
      ctrl_q    <= '0;
    end else if (!stall) begin
      wb_valid  <= ex_valid;
      ctrl_q    <= ctrl_nxt;
      wb_result <= alu_result;
      wb_wa3    <= wa3;
    end
  end

  assign pc_src    = ctrl_q.pc_src;
  assign reg_write = ctrl_q.reg_write;
  assign mem_write = ctrl_q.mem_write;

endmodule

// File: tb/tb_cond_exec_stage.sv
// Scoreboard bench for cond_exec_stage: directed vectors push expected writeback
// entries; an independent monitor pops and compares whenever writeback advances.
`timescale 1ns/1ps
module tb_cond_exec_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        ex_valid = 1'b0, stall = 1'b0, flush = 1'b0;
  logic [3:0]  cond = 4'h0, alu_flags = 4'h0;
  logic [1:0]  flag_w = 2'b00;
  logic        pcs = 1'b0, reg_w = 1'b0, mem_w = 1'b0, no_write = 1'b0;
  logic [31:0] alu_result = '0;
  logic [3:0]  wa3 = '0;
  logic        cond_ex;
  logic [3:0]  flags;
  logic        wb_valid, pc_src, reg_write, mem_write;
  logic [31:0] wb_result;
  logic [3:0]  wb_wa3;

  cond_exec_stage #(.DW(32), .AW(4)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .stall(stall), .flush(flush),
    .cond(cond), .alu_flags(alu_flags), .flag_w(flag_w), .pcs(pcs), .reg_w(reg_w),
    .mem_w(mem_w), .no_write(no_write), .alu_result(alu_result), .wa3(wa3),
    .cond_ex(cond_ex), .flags(flags), .wb_valid(wb_valid), .pc_src(pc_src),
    .reg_write(reg_write), .mem_write(mem_write), .wb_result(wb_result), .wb_wa3(wb_wa3)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        pc_src;
    logic        reg_write;
    logic        mem_write;
    logic [31:0] result;
    logic [3:0]  wa3;
  } exp_t;

  exp_t       exp_q[$];
  int         vectors = 0;
  int         miscompares = 0;
  logic [3:0] m_flags = 4'h0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  // Reference decode: odd codes invert the preceding even code, 1111 is reserved.
  function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, base;
    {n, z, cy, v} = f;
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy & ~z;
      3'd5: base = (n == v);
      3'd6: base = ~z & (n == v);
      default: base = 1'b1;
    endcase
    if (c == 4'hF) return 1'b0;
    return c[0] ? ~base : base;
  endfunction

  // Drive one cycle of stimulus from a negedge; returns at the following negedge.
  task automatic drive(input logic v, input logic st, input logic fl, input logic [3:0] c,
                       input logic [1:0] fw, input logic [3:0] af, input logic p,
                       input logic rw, input logic mw, input logic nw,
                       input logic [31:0] res, input logic [3:0] wa);
    logic pass;
    exp_t e;
    ex_valid = v; stall = st; flush = fl; cond = c; flag_w = fw; alu_flags = af;
    pcs = p; reg_w = rw; mem_w = mw; no_write = nw; alu_result = res; wa3 = wa;
    #1;
    pass = ref_cond(c, m_flags);
    check("cond_ex", {63'd0, cond_ex}, {63'd0, pass});
    if (v && !st && !fl) begin
      e.pc_src    = pass & p;
      e.reg_write = pass & rw & ~nw;
      e.mem_write = pass & mw;
      e.result    = res;
      e.wa3       = wa;
      exp_q.push_back(e);
      if (pass && fw[1]) m_flags[3:2] = af[3:2];
      if (pass && fw[0]) m_flags[1:0] = af[1:0];
    end
    @(posedge clk);
    @(negedge clk);
    check("flags", {60'd0, flags}, {60'd0, m_flags});
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 4'h0, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0);
  endtask

  // Monitor: learns from the handshake inputs at each edge what the outputs must do.
  logic        seen = 1'b0, stall_s = 1'b0, flush_s = 1'b0;
  logic [39:0] prev_out = '0;
  logic [39:0] cur_out;
  assign cur_out = {wb_valid, pc_src, reg_write, mem_write, wb_result, wb_wa3};

  always @(posedge clk) begin
    seen    = rst_n;
    stall_s = stall;
    flush_s = flush;
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && seen) begin
      if (flush_s) begin
        check("flush_valid", {63'd0, wb_valid}, 64'd0);
        check("flush_strobes", {61'd0, pc_src, reg_write, mem_write}, 64'd0);
      end else if (stall_s) begin
        check("stall_hold", {24'd0, cur_out}, {24'd0, prev_out});
      end else if (wb_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_wb", {63'd0, wb_valid}, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("wb_entry", {25'd0, pc_src, reg_write, mem_write, wb_result, wb_wa3},
                {25'd0, e});
        end
      end
    end
    prev_out = cur_out;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  localparam logic [3:0] EQ = 4'h0, NE = 4'h1, AL = 4'hE;

  initial begin
    // Reset state, observed before any clock edge
    #1 rst_n = 1'b0;
    #1;
    check("rst_outputs", {24'd0, cur_out}, 64'd0);
    check("rst_flags", {60'd0, flags}, 64'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // 1: AL with reg_w, both flag halves written
    drive(1, 0, 0, AL, 2'b11, 4'b0100, 0, 1, 0, 0, 32'h0000_0011, 4'h1);
    check("t1_flags", {60'd0, flags}, 64'h4);
    check("t1_reg_write", {62'd0, wb_valid, reg_write}, 64'h3);

    // 2: EQ passes (Z=1), NE fails, compare-type suppresses reg write
    drive(1, 0, 0, EQ, 2'b00, 4'h0, 0, 0, 1, 0, 32'h0000_0022, 4'h2);
    check("t2_eq_mem", {63'd0, mem_write}, 64'h1);
    drive(1, 0, 0, NE, 2'b00, 4'h0, 0, 0, 1, 0, 32'h0000_0033, 4'h3);
    check("t2_ne_nop", {60'd0, wb_valid, pc_src, reg_write, mem_write}, 64'h8);
    drive(1, 0, 0, AL, 2'b00, 4'h0, 0, 1, 0, 1, 32'h0000_0044, 4'h4);
    check("t2_no_write", {63'd0, reg_write}, 64'h0);
    check("t2_flags", {60'd0, flags}, 64'h4);

    // 3: partial flag writes, then a failing instruction must not touch flags
    drive(1, 0, 0, AL, 2'b10, 4'b1011, 0, 0, 0, 0, 32'h0000_0055, 4'h5);
    check("t3_nz_only", {60'd0, flags}, 64'h8);
    drive(1, 0, 0, AL, 2'b01, 4'b1011, 0, 0, 0, 0, 32'h0000_0066, 4'h6);
    check("t3_cv_only", {60'd0, flags}, 64'hB);
    drive(1, 0, 0, EQ, 2'b11, 4'b0100, 0, 0, 0, 0, 32'h0000_0077, 4'h7);
    check("t3_fail_keeps", {60'd0, flags}, 64'hB);

    // 4: three stalled cycles, then the held instruction advances exactly once
    for (int i = 0; i < 3; i++)
      drive(1, 1, 0, AL, 2'b11, 4'b0000, 0, 1, 0, 0, 32'h0000_BEEF, 4'h9);
    check("t4_stall_flags", {60'd0, flags}, 64'hB);
    drive(1, 0, 0, AL, 2'b11, 4'b0000, 0, 1, 0, 0, 32'h0000_BEEF, 4'h9);
    check("t4_release", {28'd0, wb_valid, reg_write, wb_result}, {28'd0, 2'b11, 32'h0000_BEEF});
    idle();
    check("t4_once", {63'd0, wb_valid}, 64'h0);

    // 5: flush wins over stall
    drive(1, 0, 0, AL, 2'b00, 4'h0, 1, 0, 0, 0, 32'h0000_1234, 4'h5);
    check("t5_pc_src_set", {63'd0, pc_src}, 64'h1);
    drive(1, 1, 1, AL, 2'b11, 4'b1010, 1, 0, 0, 0, 32'h0000_5678, 4'h6);
    check("t5_valid", {63'd0, wb_valid}, 64'h0);
    check("t5_pc_src", {63'd0, pc_src}, 64'h0);
    check("t5_data_hold", {32'd0, wb_result}, 64'h1234);
    check("t5_flags", {60'd0, flags}, 64'h0);

    // 6: full condition x flags sweep
    for (int f = 0; f < 16; f++) begin
      drive(1, 0, 0, AL, 2'b11, f[3:0], 0, 0, 0, 0, 32'(f), 4'h0);
      for (int c = 0; c < 16; c++)
        drive(0, 0, 0, c[3:0], 2'b00, 4'h0, 0, 0, 0, 0, 32'h0, 4'h0);
    end

    // Mid-run async reset, then EQ must fail and NE pass on cleared flags
    drive(1, 0, 0, AL, 2'b11, 4'b1111, 0, 1, 0, 0, 32'h0000_00AA, 4'hA);
    check("pre_rst_valid", {63'd0, wb_valid}, 64'h1);
    #2 rst_n = 1'b0;
    m_flags = 4'h0;
    #1;
    check("async_rst_outputs", {24'd0, cur_out}, 64'd0);
    check("async_rst_flags", {60'd0, flags}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 0, 0, EQ, 2'b00, 4'h0, 0, 1, 0, 0, 32'h0000_00BB, 4'hB);
    check("post_rst_eq", {62'd0, wb_valid, reg_write}, 64'h2);
    drive(1, 0, 0, NE, 2'b00, 4'h0, 0, 1, 0, 0, 32'h0000_00CC, 4'hC);
    check("post_rst_ne", {62'd0, wb_valid, reg_write}, 64'h3);

    idle();
    idle();
    check("sb_drain", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
